board_ctl: RTL and testbench
============================

// Module: board_ctl
// PURPOSE
//  Tic-tac-toe game controller. Sits directly upstream of the draw_square1..9 chain.
//  - Maps mouse cursor position to one of 9 board cells; square[] drives the draw_squareN inputs (square[1] -> draw_square2.square2).
//  - Registers mouse clicks, keeps X/O board state, alternates turns, and detects win/draw.
// PARAMETERS
//  COL1_START  344   first hcount of middle column (left column = 0..COL1_START-1)
//  COL2_START  680   first hcount of right column
//  ROW1_START  252   first vcount of middle row (top row = 0..ROW1_START-1)
//  ROW2_START  516   first vcount of bottom row
//  H_ACTIVE    1024  xpos >= H_ACTIVE is outside the board
//  V_ACTIVE    768   ypos >= V_ACTIVE is outside the board
// PORTS
//  pclk        in   1   pixel clock, all logic on rising edge
//  rst         in   1   synchronous reset, active high
//  start_en    in   1   game enabled (menu passed); low = abort/idle
//  mouse_xpos  in   12  cursor x, pclk domain
//  mouse_ypos  in   12  cursor y, pclk domain
//  mouse_left  in   1   left button level, pclk domain
//  square      out  9   one-hot hovered cell, idx = row*3+col, [0]=top-left
//  board_x     out  9   cells held by X, same indexing
//  board_o     out  9   cells held by O
//  turn_o      out  1   0 = X to move, 1 = O to move
//  game_over   out  1   game finished
//  winner      out  2   00 none, 01 X, 10 O, 11 draw
// BEHAVIOUR
//  - Reset: rst=1 at edge -> state IDLE, every output 0, click_prev=0. rst overrides all.
//  - Cell map: col = x<COL1_START ? 0 : x<COL2_START ? 1 : 2 (x<H_ACTIVE); rows likewise from ROW*_START/V_ACTIVE.
//    Outside the active area = no cell.
//  - Click event: mouse_left=1 and click_prev=0. click_prev <= mouse_left every cycle in all states, so a held button yields exactly one event.
//  - FSM:
//    IDLE:  square=0, boards held at 0. start_en=1 -> PLAY.
//    PLAY:  square <= one-hot of hovered cell (1-cycle latency; 0 if outside).
//           click on empty cell -> set bit in board_x (turn_o=0) or board_o (turn_o=1), -> CHECK.
//           click on occupied/outside cell ignored, stay in PLAY.
//    CHECK: one cycle; square keeps tracking. Evaluate 8 lines (3 rows, 3 cols, 2 diagonals) on the board of the player who just moved.
//           line complete -> OVER, winner=01/10, game_over=1.
//           else all 9 cells filled -> OVER, winner=11, game_over=1.
//           else turn_o toggles, -> PLAY. Click during CHECK is ignored.
//    OVER:  square=0, boards/winner held. Click event -> boards=0, turn_o=0, winner=0, game_over=0, -> PLAY.
//  - start_en=0 in any non-IDLE state -> IDLE next cycle: boards, turn_o, winner, game_over, square all cleared.
//    start_en=0 has priority over a simultaneous click.
//  - Latency: click edge at cycle n -> board bit set at n+1 -> turn_o/game_over/winner valid at n+2.
//  - Win and full board on the same move -> winner = player, never 11.
//  - board_x & board_o == 0 always holds (assertion).
// TESTING
//  1. rst=1 then 0, start_en=0 -> all outputs 0; start_en=1 -> PLAY next cycle, square follows cursor.
//  2. Hover (500,100) -> square=9'b000000010 one cycle later; (344,252) -> 9'b000010000; (1023,767) -> 9'b100000000; (1024,0) -> 0.
//  3. Click (100,100), button held 50 cycles -> board_x=9'b000000001, turn_o=1 at n+2, single move.
//     Click same cell again -> no change, turn_o stays 1.
//  4. X at 0,4,8 interleaved with O at 1,2 -> game_over=1, winner=01, square=0.
//     Next click -> all cleared, turn_o=0, PLAY.
//  5. Moves X0 O1 X2 O4 X3 O5 X7 O6 X8 -> board_x=9'b110001101, board_o=9'b001110010, winner=11.
//  6. Mid-game start_en=0 coincident with click on empty cell -> no move recorded, boards=0, IDLE next cycle.
//     rst mid-CHECK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/board_if.sv
// board_if: mouse/enable inputs and board status outputs of the game controller
interface board_if;
  logic start_en;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic mouse_left;
  logic [8:0] square;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic turn_o;
  logic game_over;
  logic [1:0] winner;
  modport master(
    output start_en, mouse_xpos, mouse_ypos, mouse_left,
    input square, board_x, board_o, turn_o, game_over, winner
  );
  modport slave(
    input start_en, mouse_xpos, mouse_ypos, mouse_left,
    output square, board_x, board_o, turn_o, game_over, winner
  );
endinterface

// File: rtl/board_ctl.sv
// board_ctl: tic-tac-toe controller mapping the cursor to cells and tracking moves and results
module board_ctl #(
  parameter int COL1_START = 344,
  parameter int COL2_START = 680,
  parameter int ROW1_START = 252,
  parameter int ROW2_START = 516,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input logic pclk,
  input logic rst,
  board_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;
  state_t state, state_nx;
  logic [8:0] square, square_nx, board_x, board_x_nx, board_o, board_o_nx, hover, mover;
  logic turn_o, turn_o_nx, game_over, game_over_nx, click_prev, click, win;
  logic [1:0] winner, winner_nx, col, row;
  logic [3:0] idx;
  assign col = bus.mouse_xpos < COL1_START ? 2'd0 : bus.mouse_xpos < COL2_START ? 2'd1 : 2'd2;
  assign row = bus.mouse_ypos < ROW1_START ? 2'd0 : bus.mouse_ypos < ROW2_START ? 2'd1 : 2'd2;
  assign idx = 4'(row * 3 + col);
  assign hover = (bus.mouse_xpos < H_ACTIVE && bus.mouse_ypos < V_ACTIVE) ? 9'd1 << idx : '0;
  assign click = bus.mouse_left & ~click_prev;
  assign mover = turn_o ? board_o : board_x;
  assign win = (mover & 9'h007) == 9'h007 || (mover & 9'h038) == 9'h038 ||
               (mover & 9'h1c0) == 9'h1c0 || (mover & 9'h049) == 9'h049 ||
               (mover & 9'h092) == 9'h092 || (mover & 9'h124) == 9'h124 ||
               (mover & 9'h111) == 9'h111 || (mover & 9'h054) == 9'h054;
  // next-state and next-output logic; dropping start_en overrides everything else
  always_comb begin
    state_nx = state;
    square_nx = '0;
    board_x_nx = board_x;
    board_o_nx = board_o;
    turn_o_nx = turn_o;
    game_over_nx = game_over;
    winner_nx = winner;
    if (!bus.start_en) begin
      state_nx = IDLE;
      board_x_nx = '0;
      board_o_nx = '0;
      turn_o_nx = 1'b0;
      game_over_nx = 1'b0;
      winner_nx = 2'b00;
    end else begin
      case (state)
        IDLE: state_nx = PLAY;
        PLAY: begin
          square_nx = hover;
          if (click && hover != '0 && (hover & (board_x | board_o)) == '0) begin
            board_x_nx = turn_o ? board_x : board_x | hover;
            board_o_nx = turn_o ? board_o | hover : board_o;
            state_nx = CHECK;
          end
        end
        CHECK: begin
          square_nx = (win || &(board_x | board_o)) ? '0 : hover;
          state_nx = (win || &(board_x | board_o)) ? OVER : PLAY;
          game_over_nx = win || &(board_x | board_o);
          winner_nx = win ? (turn_o ? 2'b10 : 2'b01) : &(board_x | board_o) ? 2'b11 : 2'b00;
          turn_o_nx = (win || &(board_x | board_o)) ? turn_o : ~turn_o;
        end
        default: if (click) begin
          state_nx = PLAY;
          board_x_nx = '0;
          board_o_nx = '0;
          turn_o_nx = 1'b0;
          game_over_nx = 1'b0;
          winner_nx = 2'b00;
        end
      endcase
    end
  end
  // state and output registers; click_prev follows the button in every state
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      square <= '0;
      board_x <= '0;
      board_o <= '0;
      turn_o <= 1'b0;
      game_over <= 1'b0;
      winner <= 2'b00;
      click_prev <= 1'b0;
    end else begin
      state <= state_nx;
      square <= square_nx;
      board_x <= board_x_nx;
      board_o <= board_o_nx;
      turn_o <= turn_o_nx;
      game_over <= game_over_nx;
      winner <= winner_nx;
      click_prev <= bus.mouse_left;
    end
  end
  assign bus.square = square;
  assign bus.board_x = board_x;
  assign bus.board_o = board_o;
  assign bus.turn_o = turn_o;
  assign bus.game_over = game_over;
  assign bus.winner = winner;
  a_disjoint: assert property (@(posedge pclk) (board_x & board_o) == '0);
endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: directed tests of the tic-tac-toe controller
module tb_board_ctl;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int xs[3] = '{100, 500, 800};
  int ys[3] = '{100, 300, 600};
  board_if bus();
  board_ctl dut(.pclk(pclk), .rst(rst), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask
  task automatic pos(input int x, input int y);
    bus.mouse_xpos = 12'(x);
    bus.mouse_ypos = 12'(y);
  endtask
  task automatic move(input int c);
    pos(xs[c % 3], ys[c / 3]);
    bus.mouse_left = 1'b1;
    step();
    bus.mouse_left = 1'b0;
    step();
  endtask
  task automatic restart();
    bus.mouse_left = 1'b1;
    step();
    bus.mouse_left = 1'b0;
    step();
  endtask
  task automatic check_all(input string tag, input logic [8:0] sq, input logic [8:0] bx,
                           input logic [8:0] bo, input logic t, input logic go, input logic [1:0] w);
    check({tag, ".square"}, 32'(bus.square), 32'(sq));
    check({tag, ".board_x"}, 32'(bus.board_x), 32'(bx));
    check({tag, ".board_o"}, 32'(bus.board_o), 32'(bo));
    check({tag, ".turn_o"}, 32'(bus.turn_o), 32'(t));
    check({tag, ".game_over"}, 32'(bus.game_over), 32'(go));
    check({tag, ".winner"}, 32'(bus.winner), 32'(w));
  endtask
  initial begin
    bus.start_en = 1'b0;
    bus.mouse_left = 1'b0;
    pos(500, 100);
    #1;
    step(2);
    rst = 1'b0;
    step();
    check_all("reset", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'b00);
    bus.start_en = 1'b1;
    step();
    check("idle_square", 32'(bus.square), 32'h0);
    step();
    check("hover_500_100", 32'(bus.square), 32'h002);
    pos(344, 252);
    step();
    check("hover_344_252", 32'(bus.square), 32'h010);
    pos(1023, 767);
    step();
    check("hover_1023_767", 32'(bus.square), 32'h100);
    pos(1024, 0);
    step();
    check("hover_1024_0", 32'(bus.square), 32'h000);
    pos(100, 100);
    bus.mouse_left = 1'b1;
    step();
    check("held_n1_bx", 32'(bus.board_x), 32'h001);
    check("held_n1_turn", 32'(bus.turn_o), 32'h0);
    step();
    check("held_n2_turn", 32'(bus.turn_o), 32'h1);
    step(48);
    check_all("held_50", 9'h001, 9'h001, 9'h000, 1'b1, 1'b0, 2'b00);
    bus.mouse_left = 1'b0;
    step();
    move(0);
    step();
    check("reclick_bx", 32'(bus.board_x), 32'h001);
    check("reclick_bo", 32'(bus.board_o), 32'h000);
    check("reclick_turn", 32'(bus.turn_o), 32'h1);
    pos(1024, 0);
    restart();
    check("outside_bo", 32'(bus.board_o), 32'h000);
    check("outside_turn", 32'(bus.turn_o), 32'h1);
    move(1);
    move(4);
    move(2);
    check("mid_turn", 32'(bus.turn_o), 32'h0);
    move(8);
    check_all("xwin", 9'h000, 9'h111, 9'h006, 1'b0, 1'b1, 2'b01);
    bus.mouse_left = 1'b1;
    step();
    check_all("restart", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'b00);
    bus.mouse_left = 1'b0;
    step();
    foreach (xs[i]) begin end
    move(0); move(1); move(2); move(4); move(3); move(5); move(7); move(6);
    check("pre_draw_over", 32'(bus.game_over), 32'h0);
    move(8);
    check_all("draw", 9'h000, 9'h18d, 9'h072, 1'b0, 1'b1, 2'b11);
    restart();
    move(5); move(3); move(6); move(4); move(0); move(7); move(1); move(8); move(2);
    check_all("full_win", 9'h000, 9'h067, 9'h198, 1'b0, 1'b1, 2'b01);
    restart();
    move(0);
    check("pre_abort_bx", 32'(bus.board_x), 32'h001);
    pos(xs[1], ys[1]);
    bus.start_en = 1'b0;
    bus.mouse_left = 1'b1;
    step();
    check_all("abort", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'b00);
    bus.mouse_left = 1'b0;
    step();
    check("abort_hold_bx", 32'(bus.board_x), 32'h0);
    bus.start_en = 1'b1;
    step(3);
    check("replay_square", 32'(bus.square), 32'h010);
    bus.mouse_left = 1'b1;
    step();
    check("pre_rst_bx", 32'(bus.board_x), 32'h010);
    rst = 1'b1;
    bus.mouse_left = 1'b0;
    step();
    rst = 1'b0;
    check_all("rst_check", 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
